// File: rtl/rv32_csr_access_unit.sv
// rv32_csr_access_unit: Zicsr read-modify-write initiator towards the CSR bank.
// Ports:
//   clk_i, resetn_i          clock, synchronous active-low reset
//   req_*_i / req_ready_o    decoded Zicsr instruction in (funct3, csr id, rs1 value, rs1 idx/zimm, rd idx)
//   csr_read_id_o            bank read port id, csr_read_value_i is its combinational data
//   csr_write_request_o      {write, id, value} towards the bank, write pulses for one cycle
//   resp_*_o / resp_ready_i  old CSR value for rd, rd write enable, illegal-instruction flag
package rv32_csr_pkg;
    typedef logic [11:0] rv_csr_id_t;
    typedef struct packed {
        logic       write;
        rv_csr_id_t id;
        logic [31:0] value;
    } csr_write_request_t;
endpackage

module rv32_csr_access_unit
    import rv32_csr_pkg::*;
#(
    parameter bit RO_CHECK = 1'b1,
    parameter bit HOLD_ID  = 1'b1
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_funct3_i,
    input  rv_csr_id_t         req_csr_id_i,
    input  logic [31:0]        req_rs1_value_i,
    input  logic [4:0]         req_rs1_idx_i,
    input  logic [4:0]         req_rd_idx_i,
    output rv_csr_id_t         csr_read_id_o,
    input  logic [31:0]        csr_read_value_i,
    output csr_write_request_t csr_write_request_o,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [4:0]         resp_rd_idx_o,
    output logic [31:0]        resp_rd_value_o,
    output logic               resp_rd_write_o,
    output logic               resp_illegal_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    state_t             state_q;
    logic [2:0]         f3_q;
    rv_csr_id_t         id_q;
    rv_csr_id_t         read_id_q;
    logic [31:0]        rs1_value_q;
    logic [4:0]         rs1_idx_q;
    logic [4:0]         rd_idx_q;
    logic [31:0]        old_q;
    logic               valid_q;
    logic               rd_write_q;
    logic               illegal_q;
    csr_write_request_t wreq_q;

    logic [31:0] src;
    logic [31:0] new_d;
    logic        wr_attempt;
    logic        illegal_d;
    logic        do_write_d;

    // RMW result is formed from the live bank data during ST_READ.
    always_comb begin
        src        = f3_q[2] ? {27'b0, rs1_idx_q} : rs1_value_q;
        wr_attempt = (f3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        illegal_d  = (f3_q[1:0] == 2'b00) || (RO_CHECK && id_q[11:10] == 2'b11 && wr_attempt);
        new_d      = f3_q[1:0] == 2'b01 ? src :
                     f3_q[1:0] == 2'b10 ? (csr_read_value_i | src) : (csr_read_value_i & ~src);
        do_write_d = wr_attempt && !illegal_d;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= ST_IDLE;
            f3_q        <= '0;
            id_q        <= '0;
            read_id_q   <= '0;
            rs1_value_q <= '0;
            rs1_idx_q   <= '0;
            rd_idx_q    <= '0;
            old_q       <= '0;
            valid_q     <= 1'b0;
            rd_write_q  <= 1'b0;
            illegal_q   <= 1'b0;
            wreq_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid_i) begin
                    f3_q        <= req_funct3_i;
                    id_q        <= req_csr_id_i;
                    read_id_q   <= req_csr_id_i;
                    rs1_value_q <= req_rs1_value_i;
                    rs1_idx_q   <= req_rs1_idx_i;
                    rd_idx_q    <= req_rd_idx_i;
                    state_q     <= ST_READ;
                end
                ST_READ: begin
                    old_q      <= csr_read_value_i;
                    wreq_q     <= '{write: do_write_d, id: id_q, value: new_d};
                    illegal_q  <= illegal_d;
                    rd_write_q <= (rd_idx_q != 5'd0) && !illegal_d;
                    read_id_q  <= HOLD_ID ? read_id_q : '0;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    wreq_q  <= '0;
                    valid_q <= 1'b1;
                    state_q <= ST_RESP;
                end
                ST_RESP: if (resp_ready_i) begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Gating with resetn keeps a write pending in ST_WRITE from reaching the bank in a reset cycle.
    assign csr_write_request_o = resetn_i ? wreq_q : '0;
    assign req_ready_o         = resetn_i && (state_q == ST_IDLE);
    assign csr_read_id_o       = read_id_q;
    assign resp_valid_o        = valid_q;
    assign resp_rd_idx_o       = rd_idx_q;
    assign resp_rd_value_o     = old_q;
    assign resp_rd_write_o     = rd_write_q;
    assign resp_illegal_o      = illegal_q;
endmodule

// File: tb/tb_rv32_csr_access_unit.sv
// tb_rv32_csr_access_unit: randomized and directed checks of the CSR access unit against a bank model.
module tb_rv32_csr_access_unit;
    import rv32_csr_pkg::*;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [2:0]         req_funct3 = '0;
    rv_csr_id_t         req_csr_id = '0;
    logic [31:0]        req_rs1_value = '0;
    logic [4:0]         req_rs1_idx = '0;
    logic [4:0]         req_rd_idx = '0;
    rv_csr_id_t         csr_read_id;
    logic [31:0]        csr_read_value;
    csr_write_request_t csr_write_request;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [4:0]         resp_rd_idx;
    logic [31:0]        resp_rd_value;
    logic               resp_rd_write;
    logic               resp_illegal;

    int checks = 0;
    int failures = 0;

    logic [31:0] bank [4096];
    logic        pre_en = 1'b0;
    rv_csr_id_t  pre_id = '0;
    logic [31:0] pre_val = '0;

    always #5 clk = ~clk;

    assign csr_read_value = bank[csr_read_id];

    always @(posedge clk) begin
        if (csr_write_request.write) bank[csr_write_request.id] <= csr_write_request.value;
        else if (pre_en) bank[pre_id] <= pre_val;
    end

    rv32_csr_access_unit dut (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_funct3_i(req_funct3), .req_csr_id_i(req_csr_id),
        .req_rs1_value_i(req_rs1_value), .req_rs1_idx_i(req_rs1_idx), .req_rd_idx_i(req_rd_idx),
        .csr_read_id_o(csr_read_id), .csr_read_value_i(csr_read_value),
        .csr_write_request_o(csr_write_request),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rd_idx_o(resp_rd_idx), .resp_rd_value_o(resp_rd_value),
        .resp_rd_write_o(resp_rd_write), .resp_illegal_o(resp_illegal)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Architectural Zicsr semantics: what the instruction should do to the CSR and to rd.
    function automatic void model(input logic [2:0] f3, input rv_csr_id_t id, input logic [31:0] rs1v,
                                  input logic [4:0] rs1i, input logic [4:0] rd, input logic [31:0] old,
                                  output bit wr, output logic [31:0] nv, output bit ill, output bit rdw);
        logic [31:0] src;
        bit          touches;
        src = (f3 >= 3'd4) ? 32'(rs1i) : rs1v;
        case (f3)
            3'd1, 3'd5: begin nv = src;         touches = 1'b1;        end
            3'd2, 3'd6: begin nv = old | src;   touches = (rs1i != 0); end
            3'd3, 3'd7: begin nv = old & ~src;  touches = (rs1i != 0); end
            default:    begin nv = old;         touches = 1'b0;        end
        endcase
        ill = (f3 == 3'd0) || (f3 == 3'd4) || (id >= 12'hC00 && touches);
        wr  = touches && !ill;
        rdw = (rd != 0) && !ill;
    endfunction

    task automatic set_csr(input rv_csr_id_t id, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_id = id; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] f3, input rv_csr_id_t id, input logic [31:0] rs1v,
                           input logic [4:0] rs1i, input logic [4:0] rd, input int hold);
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] wval;
        bit          ewr, eill, erdw;
        rv_csr_id_t  wid;
        int          w, lat, nwr, wcyc;
        old = bank[id];
        model(f3, id, rs1v, rs1i, rd, old, ewr, nv, eill, erdw);
        w = 0; lat = 0; nwr = 0; wcyc = 0; wval = '0; wid = '0;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
            return;
        end
        req_valid = 1'b1; req_funct3 = f3; req_csr_id = id;
        req_rs1_value = rs1v; req_rs1_idx = rs1i; req_rd_idx = rd;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (csr_read_id !== id) begin
            failures++;
            $display("FAIL read_id: got %h required %h", csr_read_id, id);
        end
        for (int k = 1; k <= 8; k++) begin
            if (csr_write_request.write) begin nwr++; wid = csr_write_request.id; wval = csr_write_request.value; wcyc = k; end
            if (resp_valid) begin lat = k; break; end
            @(negedge clk);
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL latency f3=%0d id=%h: got %0d required 3", f3, id, lat);
        end
        checks++;
        if (nwr != int'(ewr)) begin
            failures++;
            $display("FAIL write_count f3=%0d id=%h: got %0d required %0d", f3, id, nwr, int'(ewr));
        end
        if (ewr) begin
            checks++;
            if ({wid, wval} !== {id, nv} || wcyc != 2) begin
                failures++;
                $display("FAIL write_req: got id=%h val=%h cyc=%0d required id=%h val=%h cyc=2", wid, wval, wcyc, id, nv);
            end
        end
        checks++;
        if ({resp_rd_idx, resp_rd_value, resp_rd_write, resp_illegal} !== {rd, old, erdw, eill}) begin
            failures++;
            $display("FAIL resp f3=%0d id=%h: got rd=%0d val=%h w=%0b ill=%0b required rd=%0d val=%h w=%0b ill=%0b",
                     f3, id, resp_rd_idx, resp_rd_value, resp_rd_write, resp_illegal, rd, old, erdw, eill);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (!resp_valid || req_ready || csr_write_request.write ||
                {resp_rd_idx, resp_rd_value, resp_rd_write, resp_illegal} !== {rd, old, erdw, eill}) begin
                failures++;
                $display("FAIL hold cycle %0d: valid=%0b ready=%0b wr=%0b val=%h required valid=1 ready=0 wr=0 val=%h",
                         h, resp_valid, req_ready, csr_write_request.write, resp_rd_value, old);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake: valid=%0b ready=%0b required valid=0 ready=1", resp_valid, req_ready);
        end
        checks++;
        if (bank[id] !== (ewr ? nv : old)) begin
            failures++;
            $display("FAIL bank_value id=%h: got %h required %h", id, bank[id], ewr ? nv : old);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, csr_write_request, csr_read_id, resp_rd_idx, resp_rd_value, resp_rd_write, resp_illegal} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b wr=%0b rid=%h val=%h required all 0",
                     req_ready, resp_valid, csr_write_request.write, csr_read_id, resp_rd_value);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %0b required 1", req_ready);
        end
    endtask

    task automatic test_directed();
        set_csr(12'h340, 32'h0);
        run_txn(3'b001, 12'h340, 32'hDEADBEEF, 5'd5, 5'd3, 0);
        set_csr(12'h340, 32'hF0);
        run_txn(3'b010, 12'h340, 32'h12345678, 5'd0, 5'd4, 0);
        run_txn(3'b010, 12'h340, 32'h0F, 5'd1, 5'd4, 0);
        set_csr(12'h340, 32'hFF);
        run_txn(3'b111, 12'h340, 32'h0, 5'h0F, 5'd0, 0);
        set_csr(12'hC00, 32'h55);
        run_txn(3'b001, 12'hC00, 32'h1, 5'd5, 5'd2, 0);
        run_txn(3'b010, 12'hC00, 32'h1, 5'd0, 5'd2, 0);
        run_txn(3'b100, 12'h340, 32'h1, 5'd3, 5'd1, 0);
        run_txn(3'b000, 12'h340, 32'h1, 5'd3, 5'd1, 0);
    endtask

    task automatic test_backpressure();
        set_csr(12'h341, 32'hCAFE0000);
        run_txn(3'b110, 12'h341, 32'h0, 5'h1F, 5'd7, 5);
    endtask

    task automatic test_random();
        rv_csr_id_t ids [6];
        ids = '{12'h340, 12'h341, 12'h300, 12'hC00, 12'hC01, 12'hF11};
        foreach (ids[i]) set_csr(ids[i], $urandom);
        for (int n = 0; n < 40; n++) begin
            run_txn(3'($urandom_range(0, 7)), ids[$urandom_range(0, 5)], $urandom,
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int nresp;
        nresp = 0;
        resp_ready = 1'b1;
        req_funct3 = 3'b010; req_csr_id = 12'h340; req_rs1_idx = 5'd0; req_rd_idx = 5'd1;
        @(negedge clk);
        req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) acc.push_back(c);
            if (resp_valid) nresp++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        checks++;
        if (acc.size() != 3 || nresp != 3) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d resps=%0d required 3 and 3", acc.size(), nresp);
        end else begin
            checks++;
            if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
                failures++;
                $display("FAIL b2b_spacing: gaps %0d %0d required 4 4", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
    endtask

    // stage 1: reset lands in ST_READ, stage 2: reset lands in ST_WRITE.
    task automatic test_mid_reset(input int stage);
        int nwr;
        nwr = 0;
        set_csr(12'h340, 32'h1234);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_id = 12'h340;
        req_rs1_value = 32'hAAAA5555; req_rs1_idx = 5'd5; req_rd_idx = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        if (stage == 2) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (csr_write_request.write !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_%0d_in_reset: wr=%0b ready=%0b required 0 0", stage, csr_write_request.write, req_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_%0d_idle: valid=%0b ready=%0b required 0 1", stage, resp_valid, req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (csr_write_request.write) nwr++;
        end
        checks++;
        if (nwr != 0 || bank[12'h340] !== 32'h1234) begin
            failures++;
            $display("FAIL midreset_%0d_bank: writes=%0d mscratch=%h required 0 and 00001234", stage, nwr, bank[12'h340]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_mid_reset(1);
        test_mid_reset(2);
        run_txn(3'b001, 12'h340, 32'h600DF00D, 5'd2, 5'd9, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
